// File: rtl/lfsr_arb_ctrl_if.sv
// lfsr_arb_ctrl bundle: request/seed inputs and grant/random outputs.
// master drives requests, slave is the arbiter.
interface lfsr_arb_ctrl_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       REQ;
  logic [LEN_W-1:0] LEN0;
  logic [LEN_W-1:0] LEN1;
  logic [7:0]       SEED;
  logic             SEED_LD;
  logic [1:0]       GNT;
  logic [7:0]       RAND_OUT;
  logic             RAND_VALID;
  logic             DONE;
  logic             DONE_ID;

  modport master (
    output REQ, LEN0, LEN1, SEED, SEED_LD,
    input  GNT, RAND_OUT, RAND_VALID, DONE, DONE_ID
  );

  modport slave (
    input  REQ, LEN0, LEN1, SEED, SEED_LD,
    output GNT, RAND_OUT, RAND_VALID, DONE, DONE_ID
  );
endinterface

// File: rtl/lfsr_arb_ctrl.sv
// Two-requester round-robin arbiter granting bursts of 8-bit LFSR steps.
// Define LFSR_LOCKUP_GUARD_EN to escape the all-ones XNOR lockup state.
module lfsr_arb_ctrl #(
  parameter int LEN_W = 4
) (
  input logic           CLK,
  input logic           RESET,
  lfsr_arb_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_q;
  logic [LEN_W-1:0] r_cnt;
  logic             r_win;
  logic             r_prio;
  logic [1:0]       r_gnt;
  logic             r_rv;
  logic             r_done;
  logic             r_done_id;

  logic [7:0]       w_next;
  logic [7:0]       w_step;
  logic             w_pick;
  logic             w_req_win;
  logic             w_cnt_zero;

  assign w_next = {r_q[6:0], ~(r_q[7] ^ r_q[3])};

`ifdef LFSR_LOCKUP_GUARD_EN
  assign w_step = (r_q == 8'hFF) ? 8'h00 : w_next;
`else
  assign w_step = w_next;
`endif

  always_comb begin
    w_pick = r_prio;
    unique case (1'b1)
      (bus.REQ == 2'b01): w_pick = 1'b0;
      (bus.REQ == 2'b10): w_pick = 1'b1;
      default:            w_pick = r_prio;
    endcase
  end

  assign w_req_win  = bus.REQ[r_win];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_q       <= 8'h00;
      r_cnt     <= '0;
      r_win     <= 1'b0;
      r_prio    <= 1'b0;
      r_gnt     <= 2'b00;
      r_rv      <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_rv   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.SEED_LD) begin
            r_q <= bus.SEED;
          end else if (|bus.REQ) begin
            r_win   <= w_pick;
            r_prio  <= ~w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_cnt   <= w_pick ? bus.LEN1 : bus.LEN0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // dropping the granted request aborts without a step
          if (w_req_win) begin
            r_q  <= w_step;
            r_rv <= 1'b1;
            if (w_cnt_zero) begin
              r_done    <= 1'b1;
              r_done_id <= r_win;
              r_gnt     <= 2'b00;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end else begin
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT        = r_gnt;
  assign bus.RAND_OUT   = r_q;
  assign bus.RAND_VALID = r_rv;
  assign bus.DONE       = r_done;
  assign bus.DONE_ID    = r_done_id;

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
// Randomized scoreboard bench for lfsr_arb_ctrl.
// Expected step values come from an arithmetic LFSR model.
module tb_lfsr_arb_ctrl;

  logic CLK;
  logic RESET;

  lfsr_arb_ctrl_if #(.LEN_W(4)) bus ();

  lfsr_arb_ctrl #(.LEN_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int q;
    int done;
    int id;
    int gnt;
  } exp_t;

  exp_t sbq[$];

  int n_chk;
  int n_fail;

  int m_q;
  int m_prio;
  int m_last;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lfsr_model(input int v);
    int b7;
    int b3;
`ifdef LFSR_LOCKUP_GUARD_EN
    if (v == 255) return 0;
`endif
    b7 = (v / 128) % 2;
    b3 = (v / 8) % 2;
    return ((v * 2) % 256) + ((b7 == b3) ? 1 : 0);
  endfunction

  // monitor: every step or done cycle consumes one expected entry
  always @(negedge CLK) begin
    exp_t e;
    if (bus.RAND_VALID || bus.DONE) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious: got rv=%0b done=%0b expected none at %0t",
                 bus.RAND_VALID, bus.DONE, $time);
      end else begin
        e = sbq.pop_front();
        chk("rand_valid", int'(bus.RAND_VALID), 1);
        chk("rand_out", int'(bus.RAND_OUT), e.q);
        chk("done", int'(bus.DONE), e.done);
        chk("done_id", int'(bus.DONE_ID), e.id);
        chk("gnt_step", int'(bus.GNT), e.gnt);
      end
    end
  end

  task automatic do_reset(input logic [1:0] req, input logic sld);
    RESET       = 1'b1;
    bus.REQ     = req;
    bus.SEED_LD = sld;
    bus.SEED    = 8'h5A;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", int'(bus.GNT), 0);
    chk("rst_q", int'(bus.RAND_OUT), 0);
    chk("rst_rv", int'(bus.RAND_VALID), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_done_id", int'(bus.DONE_ID), 0);
    RESET       = 1'b0;
    bus.REQ     = 2'b00;
    bus.SEED_LD = 1'b0;
    m_q    = 0;
    m_prio = 0;
    m_last = 0;
  endtask

  task automatic seed_load(input int v, input logic [1:0] req);
    bus.SEED    = v[7:0];
    bus.SEED_LD = 1'b1;
    bus.REQ     = req;
    @(posedge CLK);
    #1;
    chk("seed_gnt", int'(bus.GNT), 0);
    chk("seed_q", int'(bus.RAND_OUT), v);
    bus.SEED_LD = 1'b0;
    m_q = v;
  endtask

  // mode 0: full burst, 1: drop REQ after s steps, 2: RESET after s steps
  task automatic burst(input logic [1:0] req, input int l0, input int l1,
                       input int mode, input int s, input bit hold);
    int w;
    int n;
    int steps;
    int oh;
    exp_t e;
    bus.SEED_LD = 1'b0;
    bus.REQ     = req;
    bus.LEN0    = l0[3:0];
    bus.LEN1    = l1[3:0];
    if (req == 2'b01) w = 0;
    else if (req == 2'b10) w = 1;
    else w = m_prio;
    m_prio = 1 - w;
    oh     = (w == 1) ? 2 : 1;
    n      = ((w == 1) ? l1 : l0) + 1;
    steps  = (mode == 0) ? n : s;
    for (int i = 1; i <= steps; i++) begin
      m_q    = lfsr_model(m_q);
      e.q    = m_q;
      e.done = (mode == 0 && i == n) ? 1 : 0;
      if (e.done == 1) m_last = w;
      e.id   = m_last;
      e.gnt  = (e.done == 1) ? 0 : oh;
      sbq.push_back(e);
    end
    @(posedge CLK);
    #1;
    chk("grant", int'(bus.GNT), oh);
    if (mode == 0) begin
      repeat (n) @(posedge CLK);
      #1;
      chk("gnt_end", int'(bus.GNT), 0);
      if (!hold) bus.REQ = 2'b00;
    end else if (mode == 1) begin
      repeat (s) @(posedge CLK);
      #1;
      bus.REQ = req & ~oh[1:0];
      @(posedge CLK);
      #1;
      chk("abort_gnt", int'(bus.GNT), 0);
      chk("abort_rv", int'(bus.RAND_VALID), 0);
      chk("abort_done", int'(bus.DONE), 0);
      chk("abort_q", int'(bus.RAND_OUT), m_q);
      chk("abort_id", int'(bus.DONE_ID), m_last);
      bus.REQ = 2'b00;
    end else begin
      repeat (s) @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET   = 1'b0;
      bus.REQ = 2'b00;
      chk("mrst_gnt", int'(bus.GNT), 0);
      chk("mrst_q", int'(bus.RAND_OUT), 0);
      chk("mrst_done", int'(bus.DONE), 0);
      chk("mrst_rv", int'(bus.RAND_VALID), 0);
      m_q    = 0;
      m_prio = 0;
      m_last = 0;
    end
  endtask

  initial begin
    int r;
    int md;
    int l0;
    int l1;
    int s;
    int n;
    logic [1:0] rq;
    bit hold;
    n_chk       = 0;
    n_fail      = 0;
    RESET       = 1'b1;
    bus.REQ     = 2'b00;
    bus.LEN0    = 4'd0;
    bus.LEN1    = 4'd0;
    bus.SEED    = 8'h00;
    bus.SEED_LD = 1'b0;

    do_reset(2'b00, 1'b0);
    burst(2'b01, 7, 0, 0, 0, 1'b0);
    @(posedge CLK);
    #1;

    do_reset(2'b00, 1'b0);
    for (int i = 0; i < 6; i++) burst(2'b11, 0, 0, 0, 0, 1'b1);
    bus.REQ = 2'b00;
    @(posedge CLK);
    #1;

    do_reset(2'b00, 1'b0);
    burst(2'b10, 0, 15, 1, 3, 1'b0);
    burst(2'b10, 0, 2, 0, 0, 1'b0);

    burst(2'b01, 15, 0, 2, 5, 1'b0);
    burst(2'b01, 3, 0, 0, 0, 1'b0);

    do_reset(2'b01, 1'b1);

    seed_load(8'hAA, 2'b01);
    burst(2'b01, 2, 0, 0, 0, 1'b0);

    seed_load(8'hFF, 2'b00);
    burst(2'b01, 0, 0, 0, 0, 1'b0);
    burst(2'b10, 0, 1, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 2);
      rq = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : 2'b11);
      l0 = $urandom_range(0, 15);
      l1 = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) seed_load($urandom_range(0, 255), rq);
      r = $urandom_range(0, 9);
      md = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      if (rq == 2'b01) n = l0 + 1;
      else if (rq == 2'b10) n = l1 + 1;
      else n = ((m_prio == 1) ? l1 : l0) + 1;
      s = $urandom_range(0, n - 1);
      hold = ($urandom_range(0, 1) == 1);
      burst(rq, l0, l1, md, s, hold);
    end
    bus.REQ = 2'b00;
    repeat (4) @(posedge CLK);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
